// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache
//  Description : Direct-mapped, write-back, write-allocate data cache with a
//                request/ready handshake to backing memory.
//                Optional hit/miss counters when DCACHE_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINES      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  dataRead,
    input  logic                  dataWrite,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  hit,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memRead,
    output logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReady
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hitCount,
    output logic [31:0]           missCount
`endif
);

    localparam int c_INDEX_BITS = $clog2(LINES);
    localparam int c_TAG_BITS   = ADDR_WIDTH - c_INDEX_BITS;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ST_REFILL    = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [c_TAG_BITS-1:0] r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    // Miss address is captured so a dropped request still completes its fill.
    logic [ADDR_WIDTH-1:0] r_miss_addr;

    logic                    w_req;
    logic [c_INDEX_BITS-1:0] w_index;
    logic [c_TAG_BITS-1:0]   w_tag;
    logic                    w_line_hit;
    logic [c_INDEX_BITS-1:0] w_miss_index;
    logic [c_TAG_BITS-1:0]   w_miss_tag;
    logic                    w_idle_req;
    logic                    w_store;
    logic                    w_miss_start;
    logic                    w_wb_done;
    logic                    w_fill;

    assign w_req        = dataRead | dataWrite;
    assign w_index      = address[c_INDEX_BITS-1:0];
    assign w_tag        = address[ADDR_WIDTH-1:c_INDEX_BITS];
    assign w_line_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss_index = r_miss_addr[c_INDEX_BITS-1:0];
    assign w_miss_tag   = r_miss_addr[ADDR_WIDTH-1:c_INDEX_BITS];

    assign w_idle_req   = (r_state == c_ST_IDLE) && w_req;
    assign w_store      = w_idle_req && w_line_hit && dataWrite;
    assign w_miss_start = w_idle_req && !w_line_hit;
    assign w_wb_done    = (r_state == c_ST_WRITEBACK) && memReady;
    assign w_fill       = (r_state == c_ST_REFILL) && memReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss_start) begin
                r_miss_addr <= address;
            end
            if (w_store) begin
                r_dirty[w_index] <= 1'b1;
            end
            if (w_wb_done) begin
                r_dirty[w_miss_index] <= 1'b0;
            end
            if (w_fill) begin
                r_valid[w_miss_index] <= 1'b1;
                r_dirty[w_miss_index] <= 1'b0;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_data[w_index] <= data;
        end
        if (w_fill) begin
            r_data[w_miss_index] <= memReadData;
            r_tag[w_miss_index]  <= w_miss_tag;
        end
    end

    always_comb begin
        w_next_state = r_state;
        outData      = '0;
        hit          = 1'b0;
        ready        = 1'b0;
        memAddress   = '0;
        memWriteData = '0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    if (w_line_hit) begin
                        hit   = 1'b1;
                        ready = 1'b1;
                        if (!dataWrite) begin
                            outData = r_data[w_index];
                        end
                    end else if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_next_state = c_ST_WRITEBACK;
                    end else begin
                        w_next_state = c_ST_REFILL;
                    end
                end
            end
            c_ST_WRITEBACK: begin
                memWrite     = 1'b1;
                memAddress   = {r_tag[w_miss_index], w_miss_index};
                memWriteData = r_data[w_miss_index];
                if (memReady) begin
                    w_next_state = c_ST_REFILL;
                end
            end
            c_ST_REFILL: begin
                memRead    = 1'b1;
                memAddress = r_miss_addr;
                if (memReady) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_idle_req && w_line_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hitCount  = r_hit_count;
    assign missCount = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache
//  Description : Self-checking bench for data_cache against a line-level
//                reference model and a word-addressed backing memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data;
    logic        dataRead;
    logic        dataWrite;
    logic [31:0] outData;
    logic        hit;
    logic        ready;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;
    logic        memReady;
`ifdef DCACHE_STATS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
`endif

    // Backing memory as seen by the DUT, and the architectural (coherent) view.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    // Reference model: which word address each line holds and its state.
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_addr  [LINES];
    int          m_hits;
    int          m_misses;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign memReadData = mem[memAddress[7:0]];

    data_cache #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LINES(LINES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .data(data),
        .dataRead(dataRead),
        .dataWrite(dataWrite),
        .outData(outData),
        .hit(hit),
        .ready(ready),
        .memAddress(memAddress),
        .memWriteData(memWriteData),
        .memRead(memRead),
        .memWrite(memWrite),
        .memReadData(memReadData),
        .memReady(memReady)
`ifdef DCACHE_STATS_EN
        ,
        .hitCount(hitCount),
        .missCount(missCount)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = '0;
        end
        m_hits   = 0;
        m_misses = 0;
        // Dirty data is lost on reset, so memory is the truth again.
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    endtask

    task automatic go_idle();
        dataRead  = 1'b0;
        dataWrite = 1'b0;
    endtask

    // One request from issue to completion; rand_rdy randomises memReady.
    task automatic do_req(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                          input bit rand_rdy);
        int          idx;
        bit          exp_hit;
        bit          exp_wb;
        int          exp_lat;
        int          cyc;
        bit          done;
        bit          saw_wb;
        bit          saw_rd;
        logic [31:0] vaddr;
        logic [31:0] vdata;
        logic [31:0] exp_out;
        idx     = int'(a % LINES);
        exp_hit = m_valid[idx] && (m_addr[idx] == a);
        exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        exp_lat = exp_hit ? 1 : (exp_wb ? 4 : 3);
        vaddr   = m_addr[idx];
        vdata   = ref_mem[vaddr[7:0]];
        exp_out = wr ? 32'd0 : ref_mem[a[7:0]];
        address   = a;
        data      = wd;
        dataWrite = wr;
        dataRead  = ~wr;
        cyc = 0; done = 0; saw_wb = 0; saw_rd = 0;
        while (!done && cyc < 200) begin
            memReady = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            checks++;
            if (memRead && memWrite) begin
                failures++;
                $display("FAIL mem_exclusive addr=%0d memRead=%0b memWrite=%0b required not both", a, memRead, memWrite);
            end
            checks++;
            if (hit !== ready) begin
                failures++;
                $display("FAIL hit_vs_ready addr=%0d hit=%0b required=%0b", a, hit, ready);
            end
            if (memWrite) begin
                saw_wb = 1;
                checks++;
                if (memAddress !== vaddr || memWriteData !== vdata) begin
                    failures++;
                    $display("FAIL writeback addr=%0d got %0d/%0h required %0d/%0h", a, memAddress, memWriteData, vaddr, vdata);
                end
                if (memReady) mem[memAddress[7:0]] = memWriteData;
            end
            if (memRead) begin
                saw_rd = 1;
                checks++;
                if (memAddress !== a) begin
                    failures++;
                    $display("FAIL refill_addr got %0d required %0d", memAddress, a);
                end
            end
            checks++;
            if (ready) begin
                done = 1;
                if (outData !== exp_out) begin
                    failures++;
                    $display("FAIL read_data addr=%0d wr=%0b got %0h required %0h", a, wr, outData, exp_out);
                end
            end else if (outData !== 32'd0) begin
                failures++;
                $display("FAIL outdata_idle addr=%0d got %0h required 0", a, outData);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL timeout addr=%0d ready=%0b required 1 within 200 cycles", a, ready);
        end
        if (!rand_rdy) begin
            checks++;
            if (cyc != exp_lat) begin
                failures++;
                $display("FAIL latency addr=%0d got %0d required %0d", a, cyc, exp_lat);
            end
        end
        checks++;
        if (saw_wb !== exp_wb || saw_rd !== !exp_hit) begin
            failures++;
            $display("FAIL traffic addr=%0d wb=%0b rd=%0b required wb=%0b rd=%0b", a, saw_wb, saw_rd, exp_wb, !exp_hit);
        end
        if (exp_wb) begin
            checks++;
            if (mem[vaddr[7:0]] !== ref_mem[vaddr[7:0]]) begin
                failures++;
                $display("FAIL wb_mem addr=%0d got %0h required %0h", vaddr, mem[vaddr[7:0]], ref_mem[vaddr[7:0]]);
            end
        end
        if (done) begin
            if (!exp_hit) begin
                m_misses++;
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
                m_addr[idx]  = a;
            end
            m_hits++;
            if (wr) begin
                m_dirty[idx]    = 1'b1;
                ref_mem[a[7:0]] = wd;
            end
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (hitCount !== 32'(m_hits) || missCount !== 32'(m_misses)) begin
            failures++;
            $display("FAIL stats got hit=%0d miss=%0d required hit=%0d miss=%0d", hitCount, missCount, m_hits, m_misses);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; memReady = 1'b1;
        address = 32'd3; data = 32'hdead; dataRead = 1'b1; dataWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (outData !== 0 || hit !== 0 || ready !== 0 || memRead !== 0 || memWrite !== 0 ||
            memAddress !== 0 || memWriteData !== 0) begin
            failures++;
            $display("FAIL reset_outputs got out=%0h hit=%0b rdy=%0b mr=%0b mw=%0b ma=%0h mwd=%0h required all 0",
                     outData, hit, ready, memRead, memWrite, memAddress, memWriteData);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (hitCount !== 0 || missCount !== 0) begin
            failures++;
            $display("FAIL reset_stats got %0d/%0d required 0/0", hitCount, missCount);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        go_idle();
        model_reset();
        @(negedge clk);
        checks++;
        if (ready !== 0 || hit !== 0) begin
            failures++;
            $display("FAIL idle_no_req got hit=%0b ready=%0b required 0/0", hit, ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        mem[56] = 32'h1234; ref_mem[56] = 32'h1234;
        do_req(32'd56, 1'b0, 32'd0, 1'b0);
        do_req(32'd56, 1'b0, 32'd0, 1'b0);
        do_req(32'd57, 1'b0, 32'd0, 1'b0);
        do_req(32'd68, 1'b1, 32'd4523, 1'b0);
        do_req(32'd68, 1'b0, 32'd0, 1'b0);
        do_req(32'd84, 1'b0, 32'd0, 1'b0);
        go_idle();
        checks++;
        if (mem[68] !== 32'd4523) begin
            failures++;
            $display("FAIL mem68 got %0d required 4523", mem[68]);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (missCount !== 32'd4 || hitCount !== 32'd6) begin
            failures++;
            $display("FAIL directed_stats got hit=%0d miss=%0d required hit=6 miss=4", hitCount, missCount);
        end
`endif
        @(posedge clk); #1;
    endtask

    // Address 120 shares a clean line with 56; reset lands mid-refill.
    task automatic test_reset_mid_refill();
        memReady = 1'b0; address = 32'd120; dataRead = 1'b1; dataWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (hit !== 0 || ready !== 0) begin
            failures++;
            $display("FAIL miss_idle got hit=%0b ready=%0b required 0/0", hit, ready);
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (memRead !== 1 || memAddress !== 32'd120) begin
                failures++;
                $display("FAIL refill_wait cycle=%0d memRead=%0b addr=%0d required 1/120", i, memRead, memAddress);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (memRead !== 0 || memWrite !== 0 || memAddress !== 0 || ready !== 0) begin
            failures++;
            $display("FAIL async_reset got mr=%0b mw=%0b ma=%0d rdy=%0b required 0", memRead, memWrite, memAddress, ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        go_idle();
        model_reset();
        do_req(32'd56, 1'b0, 32'd0, 1'b0);
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        do_req(32'd200, 1'b0, 32'd0, 1'b0);
        do_req(32'd200, 1'b1, v, 1'b0);
        do_req(32'd200, 1'b0, 32'd0, 1'b0);
        do_req(32'd216, 1'b0, 32'd0, 1'b0);
        do_req(32'd200, 1'b0, 32'd0, 1'b0);
        go_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_random(input bit rand_rdy, input int n);
        for (int i = 0; i < n; i++) begin
            do_req(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom, rand_rdy);
            if ($urandom_range(0, 3) == 0) begin
                go_idle();
                @(posedge clk); #1;
            end
        end
        go_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; address = '0; data = '0; dataRead = 1'b0; dataWrite = 1'b0; memReady = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #2;
        test_reset();
        test_directed();
        test_reset_mid_refill();
        test_back_to_back();
        test_random(1'b0, 80);
        test_random(1'b1, 80);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
